// File: rtl/uart_arb_pkg.sv
// ----------------------------------------------------------------------------
// uart_arb_pkg : state encoding and width helpers for uart_tx_arbiter  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // One 9600-baud bit time at a 12 MHz system clock.
  localparam int GAP_BIT_TIME_12MHZ_9600 = 1250;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int grant_w(input int n);
    return cnt_w(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter_if : producer and transmitter handshake bundle  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_done;

  modport master (
    input  req_valid, req_data, tx_done,
    output req_ready, tx_data, tx_start
  );

  modport slave (
    output req_valid, req_data, tx_done,
    input  req_ready, tx_data, tx_start
  );

endinterface

`default_nettype wire

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick : combinational round-robin priority encoder  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]          req,
  input  logic [grant_w(NUM_REQ)-1:0] last_grant,
  input  logic                        first,
  output logic [grant_w(NUM_REQ)-1:0] grant,
  output logic                        any_valid
);

  localparam int GW = grant_w(NUM_REQ);

  int base;
  int idx;

  // Scan downward in distance so the closest set bit to base is written last.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = 0;
    base      = first ? 0 : (int'(last_grant) + 1) % NUM_REQ;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (base + k) % NUM_REQ;
      if (req[GW'(idx)]) begin
        grant     = GW'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter : round-robin share of one UART transmitter; UART_ARB_TIMEOUT_EN
// adds a tx_done watchdog with a sticky timeout_err  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                        clk,
  input  logic                        resetn,
  uart_tx_arbiter_if.master           bus,
  output logic [grant_w(NUM_REQ)-1:0] grant_id,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int GW    = grant_w(NUM_REQ);
  localparam int GAP_W = cnt_w(GAP_CYCLES);

  state_t             state_q;
  state_t             state_d;
  logic [GW-1:0]      grant_d;
  logic [GW-1:0]      pick;
  logic               any_valid;
  logic [7:0]         data_q;
  logic [7:0]         data_d;
  logic               start_q;
  logic [NUM_REQ-1:0] ready_q;
  logic               first_q;
  logic               first_d;
  logic [GAP_W-1:0]   gap_q;
  logic [GAP_W-1:0]   gap_d;
  logic               to_fire;
  logic [7:0]         req_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req_bytes
    assign req_bytes[g] = bus.req_data[8*g +: 8];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req        (bus.req_valid),
    .last_grant (grant_id),
    .first      (first_q),
    .grant      (pick),
    .any_valid  (any_valid)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_W = cnt_w(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_q;
  logic            terr_q;

  // A tx_done on the final allowed cycle still wins over the timeout.
  assign to_fire = (state_q == ST_WAIT) && !bus.tx_done &&
                   (to_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_q   <= '0;
      terr_q <= 1'b0;
    end else begin
      to_q <= (state_q == ST_WAIT) ? to_q + TO_W'(1) : '0;
      if (to_fire) begin
        terr_q <= 1'b1;
      end
    end
  end

  assign timeout_err = terr_q;
`else
  assign to_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_id;
    data_d  = data_q;
    first_d = first_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          state_d = ST_START;
          grant_d = pick;
          data_d  = req_bytes[pick];
          first_d = 1'b0;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.tx_done) begin
          state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
          gap_d   = '0;
        end else if (to_fire) begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pulses and busy are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      grant_id <= '0;
      data_q   <= '0;
      start_q  <= 1'b0;
      ready_q  <= '0;
      busy     <= 1'b0;
      first_q  <= 1'b1;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_id <= grant_d;
      data_q   <= data_d;
      start_q  <= (state_d == ST_START);
      ready_q  <= (state_d == ST_START) ? (NUM_REQ'(1) << grant_d) : '0;
      busy     <= (state_d != ST_IDLE);
      first_q  <= first_d;
      gap_q    <= gap_d;
    end
  end

  assign bus.tx_data   = data_q;
  assign bus.tx_start  = start_q;
  assign bus.req_ready = ready_q;

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares the single 8N1 UART transmitter between NUM_REQ byte producers (status reporter, keypad echo, debug dump, ...). It accepts one byte per grant and hands it to the transmitter with a one-cycle start pulse. It then waits for the transmitter's done pulse and enforces an optional idle gap before the next grant. It sits between the producers and the transmitter, entirely in the system clock domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GAP_CYCLES, 0, idle clk cycles inserted after each tx_done before the next grant (1250 = one bit time at 9600 baud from 12 MHz)
TIMEOUT_CYCLES, 20000, max clk cycles to wait for tx_done (used only with the optional feature)

Ports:
clk  in  1  system clock (12 MHz)
resetn  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester byte available; must be held with req_data stable until matching req_ready
req_data  in  8*NUM_REQ  requester i's byte on bits [8i+7:8i]
req_ready  out  NUM_REQ  one-hot, one-cycle pulse: byte of requester i accepted
tx_data  out  8  byte to transmitter; stable from the tx_start cycle until tx_done
tx_start  out  1  one-cycle pulse to the transmitter
tx_done  in  1  transmitter finished frame (one-cycle pulse, synchronous to clk)
grant_id  out  clog2(NUM_REQ)  index of last granted requester
busy  out  1  high in every state except IDLE
timeout_err  out  1  sticky timeout flag (constant 0 without the optional feature)

Behaviour:
- Reset (async assert, sync release): state IDLE; req_ready=0, tx_start=0, tx_data=0, grant_id=0, busy=0, timeout_err=0; round-robin pointer=0. Any in-flight byte is dropped.
- All outputs are registered.
- States: IDLE, START, WAIT, GAP.
- IDLE, any req_valid set:
  - Pick the first set bit scanning upward from (last_grant+1) mod NUM_REQ, wrapping.
  - First grant after reset starts its scan at index 0.
  - Latch req_data into tx_data; set grant_id; go to START.
- START (exactly one cycle): tx_start=1 and req_ready[grant_id]=1 in this same cycle; busy=1; next state WAIT.
  - Latency from req_valid seen in IDLE to the req_ready/tx_start pulse is 1 cycle.
- WAIT: hold tx_data. On tx_done=1, go to GAP if GAP_CYCLES>0, else IDLE.
- GAP: count GAP_CYCLES cycles, then go to IDLE; busy=1 throughout.
- tx_done is honoured only in WAIT; it is ignored in IDLE, START and GAP, including a tx_done arriving in the START cycle.
- Requests arriving while not in IDLE wait; no request is ever lost while its valid is held.
- Only one requester continuously valid: granted back-to-back, one byte per frame plus gap.
- All requesters continuously valid: strict rotation 0,1,2,3,0,...
- req_valid dropping before req_ready is a protocol violation; the arbiter does not check for it.
- Minimum IDLE-to-IDLE turnaround: 3 cycles plus the transmitter frame time plus GAP_CYCLES.

Optional Feature:
UART_ARB_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT.
  - If TIMEOUT_CYCLES elapse with no tx_done, set timeout_err (sticky until reset) and go to IDLE, dropping the byte.
  - The round-robin pointer still advances past the timed-out requester.
- Undefined: no counter is built, timeout_err is tied 0, and WAIT waits indefinitely.

Decomposition:
- Package uart_arb_pkg holds:
  - state encoding constants ST_IDLE, ST_START, ST_WAIT, ST_GAP;
  - GRANT_W = clog2(NUM_REQ) as a function;
  - the default baud-derived GAP constant (1250).
- One sub-module, rr_pick: combinational round-robin priority encoder with inputs req vector and last_grant, outputs grant index and any_valid.

Test Plan:
- Reset mid-WAIT with tx_data=8'h41 → all outputs 0 immediately on reset assert; after release, the first grant goes to requester 0 when requesters 0 and 2 are both valid.
- Only req 1 valid, data 8'h5A, transmitter model returns tx_done 12 cycles after tx_start, GAP_CYCLES=0 → tx_start and req_ready=4'b0010 in the same cycle, tx_data=8'h5A held until tx_done, then IDLE.
- All 4 valid with data 8'h30..8'h33 continuously, 8 frames → grant order 0,1,2,3,0,1,2,3 with matching tx_data bytes.
- GAP_CYCLES=5 → exactly 5 cycles in GAP (busy=1) between tx_done and return to IDLE; the next tx_start comes 1 cycle after IDLE.
- tx_done pulsed in IDLE and in the START cycle → ignored; the arbiter stays in WAIT until a later tx_done.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100, tx_done never returned → timeout_err=1 after 100 WAIT cycles, then the next valid requester is granted; timeout_err stays 1.
